// File: rtl/mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_hilo_unit
//  Description : Sequencing front-end for the shift-add multiplier in the
//                MIPS datapath. Latches MULT/MULTU operands, converts signed
//                operands to magnitudes, launches the multiplier, and writes
//                the sign-corrected product into the architectural HI/LO
//                registers. Also services MTHI/MTLO writes while idle.
//  Config      : SIGNED_MULT_EN - when defined, signed MULT is supported;
//                when undefined, every request behaves as MULTU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_unit #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Req,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  input  logic               WrHi,
  input  logic               WrLo,
  input  logic [WIDTH-1:0]   WrData,
  output logic [WIDTH-1:0]   MulA,
  output logic [WIDTH-1:0]   MulB,
  output logic               MulSt,
  output logic               MulReset,
  input  logic               MulIdle,
  input  logic               MulDone,
  input  logic [2*WIDTH-1:0] MulProduto,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic               Busy,
  output logic               Fim
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_fim;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_neg;
  logic [2*WIDTH-1:0]   w_result;

`ifdef SIGNED_MULT_EN
  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is exactly its unsigned magnitude.
  assign w_mag_a  = (Signed && OpA[WIDTH-1]) ? (~OpA + 1'b1) : OpA;
  assign w_mag_b  = (Signed && OpB[WIDTH-1]) ? (~OpB + 1'b1) : OpB;
  assign w_neg    = Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
  // Full-width negation of the unsigned product; zero stays zero.
  assign w_result = r_neg ? (~MulProduto + 1'b1) : MulProduto;
`else
  // Unsigned-only build: operands and product pass straight through.
  logic w_unused;
  assign w_mag_a  = OpA;
  assign w_mag_b  = OpB;
  assign w_neg    = 1'b0;
  assign w_result = MulProduto;
  assign w_unused = &{1'b0, Signed, r_neg};
`endif

  // Control FSM plus HI/LO, operand and completion registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_neg   <= 1'b0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_fim   <= 1'b0;
    end else begin
      r_fim <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            // An accepted request takes priority over MTHI/MTLO.
            r_neg   <= w_neg;
            r_mul_a <= w_mag_a;
            r_mul_b <= w_mag_b;
            r_state <= S_LAUNCH;
          end else begin
            if (WrHi) r_hi <= WrData;
            if (WrLo) r_lo <= WrData;
          end
        end
        S_LAUNCH: begin
          if (MulIdle) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (MulDone) begin
            {r_hi, r_lo} <= w_result;
            r_fim        <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Start fires in the LAUNCH cycle in which the multiplier reports idle.
  assign MulSt    = (r_state == S_LAUNCH) & MulIdle;
  assign MulReset = ~Reset;
  assign MulA     = r_mul_a;
  assign MulB     = r_mul_b;
  assign Hi       = r_hi;
  assign Lo       = r_lo;
  assign Busy     = (r_state != S_IDLE);
  assign Fim      = r_fim;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_hilo_unit
//  Description : Self-checking bench for mult_hilo_unit with a behavioural
//                shift-add multiplier model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_unit;
  localparam int W = 16;
  localparam int LAT = 4;
`ifdef SIGNED_MULT_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, req, sgn, wr_hi, wr_lo;
  logic [W-1:0]   op_a, op_b, wr_data;
  logic [W-1:0]   mul_a, mul_b, hi, lo;
  logic           mul_st, mul_reset, mul_idle, mul_done, busy, fim;
  logic [2*W-1:0] mul_prod;

  mult_hilo_unit #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(rst_n), .Req(req), .Signed(sgn), .OpA(op_a), .OpB(op_b),
    .WrHi(wr_hi), .WrLo(wr_lo), .WrData(wr_data), .MulA(mul_a), .MulB(mul_b),
    .MulSt(mul_st), .MulReset(mul_reset), .MulIdle(mul_idle), .MulDone(mul_done),
    .MulProduto(mul_prod), .Hi(hi), .Lo(lo), .Busy(busy), .Fim(fim)
  );

  // Behavioural multiplier: fixed latency, one-cycle done pulse.
  logic m_busy;
  int   m_cnt;
  logic hold_idle;
  assign mul_idle = !m_busy && !hold_idle;

  always @(posedge clk) begin
    if (mul_reset) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      mul_done <= 1'b0;
      mul_prod <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_st) begin
        m_busy   <= 1'b1;
        m_cnt    <= LAT;
        mul_prod <= {16'b0, mul_a} * {16'b0, mul_b};
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy   <= 1'b0;
          mul_done <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_st    = 0;
  int n_fim   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] prod;
    logic [15:0] ma;
    logic [15:0] mb;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] model(bit s, logic [15:0] a, logic [15:0] b);
    logic signed [31:0] sa, sbb;
    if (s && SIGNED_EN) begin
      sa  = {{16{a[15]}}, a};
      sbb = {{16{b[15]}}, b};
      return 32'(sa * sbb);
    end
    return {16'b0, a} * {16'b0, b};
  endfunction

  function automatic logic [15:0] mag(bit s, logic [15:0] a);
    logic [15:0] r;
    r = a;
    if (s && SIGNED_EN && a[15]) r = 16'h0000 - a;
    return r;
  endfunction

  // Monitor: operand check at each start, result check at each completion.
  always @(negedge clk) begin
    exp_t e;
    if (mul_st) begin
      n_st++;
      if (sb.size() > 0) begin
        check("mul_a", 32'(mul_a), 32'(sb[0].ma));
        check("mul_b", 32'(mul_b), 32'(sb[0].mb));
      end else begin
        check("mulst_without_request", 32'(sb.size()), 32'd1);
      end
    end
    if (fim) begin
      n_fim++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hilo", {hi, lo}, e.prod);
        check("busy_at_fim", 32'(busy), 32'd0);
      end else begin
        check("fim_without_request", 32'(sb.size()), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.prod = model(s, a, b);
    e.ma   = mag(s, a);
    e.mb   = mag(s, b);
    sb.push_back(e);
    sgn  = s;
    op_a = a;
    op_b = b;
    req  = 1'b1;
    tick();
    req  = 1'b0;
  endtask

  task automatic wait_fim();
    int start;
    int k;
    start = n_fim;
    k = 0;
    while (n_fim == start && k < 100) begin
      tick();
      k++;
    end
    if (n_fim == start) check("fim_timeout", 32'(n_fim), 32'(start + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st0;
    rst_n = 1'b0; req = 1'b0; sgn = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op_a = '0; op_b = '0; wr_data = '0; hold_idle = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fim", 32'(fim), 32'd0);
    check("rst_mulst", 32'(mul_st), 32'd0);
    check("rst_mulreset", 32'(mul_reset), 32'd1);
    check("rst_mula", 32'(mul_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mulreset_release", 32'(mul_reset), 32'd0);
    tick();

    // MULTU 300 x 200
    st0 = n_st;
    issue(1'b0, 16'd300, 16'd200);
    check("busy_after_req", 32'(busy), 32'd1);
    wait_fim();
    check("multu_hi", 32'(hi), 32'h0000);
    check("multu_lo", 32'(lo), 32'hEA60);
    check("multu_st_pulses", 32'(n_st - st0), 32'd1);

    // MULT -3 x 5
    issue(1'b1, 16'hFFFD, 16'h0005);
    wait_fim();
    check("neg_hi", 32'(hi), SIGNED_EN ? 32'hFFFF : 32'h0004);
    check("neg_lo", 32'(lo), 32'hFFF1);
    check("neg_mula_held", 32'(mul_a), SIGNED_EN ? 32'h0003 : 32'hFFFD);

    // MULT most-negative squared, then zero times -1
    issue(1'b1, 16'h8000, 16'h8000);
    wait_fim();
    check("minneg_hi", 32'(hi), 32'h4000);
    check("minneg_lo", 32'(lo), 32'h0000);
    issue(1'b1, 16'h0000, 16'hFFFF);
    wait_fim();
    check("zero_hilo", {hi, lo}, 32'h0);

    // Multiplier not idle for 3 cycles after the request
    hold_idle = 1'b1;
    st0 = n_st;
    issue(1'b0, 16'h1234, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      check("st_while_not_idle", 32'(mul_st), 32'd0);
      tick();
    end
    hold_idle = 1'b0;
    #1;
    check("st_on_idle_rise", 32'(mul_st), 32'd1);
    wait_fim();
    check("held_st_pulses", 32'(n_st - st0), 32'd1);

    // Request and MTHI while busy are dropped
    issue(1'b0, 16'd7, 16'd9);
    tick();
    req = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; wr_hi = 1'b1; wr_data = 16'h1234;
    tick();
    req = 1'b0; wr_hi = 1'b0;
    wait_fim();
    for (int i = 0; i < 6; i++) tick();
    check("no_queued_req", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("busy_hilo", {hi, lo}, 32'd63);
    wr_hi = 1'b1;
    tick();
    wr_hi = 1'b0;
    check("mthi_hi", 32'(hi), 32'h1234);
    check("mthi_lo_kept", 32'(lo), 32'd63);

    // Reset mid-WAIT
    issue(1'b0, 16'h0101, 16'h0202);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_mulreset", 32'(mul_reset), 32'd1);
    tick();
    tick();
    check("midrst_hi", 32'(hi), 32'd0);
    check("midrst_lo", 32'(lo), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fim", 32'(fim), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 16'h0101, 16'h0202);
    wait_fim();
    check("post_rst_hi", 32'(hi), 32'h0002);
    check("post_rst_lo", 32'(lo), 32'h0402);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
